// File: rtl/px_level2pulse_mc_if.sv
// Bus bundle for px_level2pulse_mc: asynchronous levels and per-channel controls in,
// event pulses, pending flags and the selected counter value out.
interface px_level2pulse_mc_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]    level;
  logic [2*CH-1:0]  mode;
  logic [CH-1:0]    pulse;
  logic [CH-1:0]    pend;
  logic [CH-1:0]    pend_clr;
  logic             any_pend;
  logic [SEL_W-1:0] cnt_sel;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_val;

  modport master (
    output level, mode, pend_clr, cnt_sel, cnt_clr,
    input  pulse, pend, any_pend, cnt_val
  );

  modport slave (
    input  level, mode, pend_clr, cnt_sel, cnt_clr,
    output pulse, pend, any_pend, cnt_val
  );
endinterface

// File: rtl/px_level2pulse_mc.sv
// Multi-channel level-to-pulse converter: sync chain, optional stability filter, edge select.
// Latency from first sampling edge: SYNC_STAGES+1 edges unfiltered, SYNC_STAGES+FILTER+1 filtered.
module px_level2pulse_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 0,
  parameter int CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  px_level2pulse_mc_if.slave io
);
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CH-1:0]       pulse_vec;
  logic [CH-1:0]       pend_vec;
  logic [CH*CNT_W-1:0] cnt_flat;
  logic [CNT_W-1:0]    cnt_val_c;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic                   filt;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;
    logic                   pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             ch_mode;
    logic                   rise, fall, evt, clr_hit;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign ch_mode  = io.mode[2*i +: 2];

    if (FILTER == 0) begin : g_nofilt
      assign filt = sync_out;
    end else begin : g_filt
      localparam int FC_W = $clog2(FILTER + 1);
      logic [FC_W-1:0] fc_q, fc_d;
      logic            filt_q, filt_d;

      // filt only follows sync_out after FILTER consecutive disagreeing cycles
      always_comb begin
        fc_d   = fc_q;
        filt_d = filt_q;
        if (sync_out == filt_q) begin
          fc_d = '0;
        end else if (fc_q == FC_W'(FILTER - 1)) begin
          filt_d = ~filt_q;
          fc_d   = '0;
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          fc_q   <= '0;
          filt_q <= 1'b0;
        end else begin
          fc_q   <= fc_d;
          filt_q <= filt_d;
        end
      end

      assign filt = filt_q;
    end

    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], io.level[i]};
      prev_d  = filt;
      rise    = filt & ~prev_q;
      fall    = ~filt & prev_q;
      evt     = (rise & ch_mode[0]) | (fall & ch_mode[1]);
      clr_hit = io.cnt_clr && (io.cnt_sel == SEL_W'(i));
      pulse_d = evt;
      pend_d  = evt ? 1'b1 : (io.pend_clr[i] ? 1'b0 : pend_q);
      // a clear coinciding with an event keeps that event in the count
      if (clr_hit) begin
        cnt_d = evt ? CNT_W'(1) : '0;
      end else if (evt && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= '0;
        prev_q  <= 1'b0;
        pulse_q <= 1'b0;
        pend_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync_q  <= sync_d;
        prev_q  <= prev_d;
        pulse_q <= pulse_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
      end
    end

    assign pulse_vec[i]                 = pulse_q;
    assign pend_vec[i]                  = pend_q;
    assign cnt_flat[i*CNT_W +: CNT_W]   = cnt_q;
  end

  // unmatched (out-of-range) selects fall through to zero
  always_comb begin
    cnt_val_c = '0;
    for (int k = 0; k < CH; k++) begin
      if (io.cnt_sel == SEL_W'(k)) cnt_val_c = cnt_flat[k*CNT_W +: CNT_W];
    end
  end

  assign io.pulse    = pulse_vec;
  assign io.pend     = pend_vec;
  assign io.any_pend = |pend_vec;
  assign io.cnt_val  = cnt_val_c;
endmodule

// File: tb/tb_px_level2pulse_mc.sv
// Directed bench: unit A (4 ch, no filter, 8-bit counters), unit B (3 ch, FILTER=4, 2-bit counters).
module tb_px_level2pulse_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  px_level2pulse_mc_if #(.CH(4), .CNT_W(8)) ia ();
  px_level2pulse_mc_if #(.CH(3), .CNT_W(2)) ib ();

  px_level2pulse_mc #(.CH(4), .SYNC_STAGES(2), .FILTER(0), .CNT_W(8)) u_a (
    .clk (clk),
    .rst (rst),
    .io  (ia.slave)
  );

  px_level2pulse_mc #(.CH(3), .SYNC_STAGES(2), .FILTER(4), .CNT_W(2)) u_b (
    .clk (clk),
    .rst (rst),
    .io  (ib.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++; if (ia.pulse !== 4'h0) begin errors++; $display("FAIL rst_pulse_a got %0h exp 0", ia.pulse); end
    checks++; if (ia.pend !== 4'h0) begin errors++; $display("FAIL rst_pend_a got %0h exp 0", ia.pend); end
    checks++; if (ia.any_pend !== 1'b0) begin errors++; $display("FAIL rst_any_a got %0b exp 0", ia.any_pend); end
    checks++; if (ia.cnt_val !== 8'd0) begin errors++; $display("FAIL rst_cnt_a got %0d exp 0", ia.cnt_val); end
    checks++; if (ib.pend !== 3'h0 || ib.pulse !== 3'h0) begin errors++; $display("FAIL rst_b got pend %0h pulse %0h exp 0 0", ib.pend, ib.pulse); end
    rst = 1'b0;
  endtask

  task automatic test_rise;
    ia.cnt_sel = 2'd0;
    ia.level[0] = 1'b1;
    tick(2);
    checks++; if (ia.pulse[0] !== 1'b0) begin errors++; $display("FAIL rise_early got %0b exp 0", ia.pulse[0]); end
    tick(1);
    checks++; if (ia.pulse[0] !== 1'b1) begin errors++; $display("FAIL rise_pulse got %0b exp 1", ia.pulse[0]); end
    checks++; if (ia.pend[0] !== 1'b1 || ia.any_pend !== 1'b1) begin errors++; $display("FAIL rise_pend got %0b/%0b exp 1/1", ia.pend[0], ia.any_pend); end
    checks++; if (ia.cnt_val !== 8'd1) begin errors++; $display("FAIL rise_cnt got %0d exp 1", ia.cnt_val); end
    tick(1);
    checks++; if (ia.pulse[0] !== 1'b0) begin errors++; $display("FAIL rise_single got %0b exp 0", ia.pulse[0]); end
    ia.level[0] = 1'b0;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        tick(1);
        if (ia.pulse[0] === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rise_no_fall_pulse got %0d exp 0", seen); end
    end
    checks++; if (ia.cnt_val !== 8'd1) begin errors++; $display("FAIL rise_cnt_hold got %0d exp 1", ia.cnt_val); end
    ia.pend_clr = 4'b0001;
    tick(1);
    ia.pend_clr = 4'b0000;
    checks++; if (ia.pend[0] !== 1'b0 || ia.any_pend !== 1'b0) begin errors++; $display("FAIL pend_clr got %0b/%0b exp 0/0", ia.pend[0], ia.any_pend); end
  endtask

  task automatic test_fall;
    ia.cnt_sel = 2'd1;
    ia.level[1] = 1'b1;
    tick(6);
    checks++; if (ia.cnt_val !== 8'd0) begin errors++; $display("FAIL fall_rise_ignored got %0d exp 0", ia.cnt_val); end
    ia.level[1] = 1'b0;
    tick(3);
    checks++; if (ia.pulse[1] !== 1'b1) begin errors++; $display("FAIL fall_pulse got %0b exp 1", ia.pulse[1]); end
    tick(1);
    checks++; if (ia.cnt_val !== 8'd1) begin errors++; $display("FAIL fall_cnt got %0d exp 1", ia.cnt_val); end
  endtask

  task automatic test_both_and_off;
    int p2 = 0;
    int p3 = 0;
    for (int t = 0; t < 60; t++) begin
      if (t % 10 == 0 && t < 50) begin
        ia.level[2] = ~ia.level[2];
        ia.level[3] = ~ia.level[3];
      end
      tick(1);
      if (ia.pulse[2] === 1'b1) p2++;
      if (ia.pulse[3] === 1'b1) p3++;
    end
    checks++; if (p2 != 5) begin errors++; $display("FAIL both_pulses got %0d exp 5", p2); end
    ia.cnt_sel = 2'd2;
    tick(1);
    checks++; if (ia.cnt_val !== 8'd5) begin errors++; $display("FAIL both_cnt got %0d exp 5", ia.cnt_val); end
    checks++; if (p3 != 0 || ia.pend[3] !== 1'b0) begin errors++; $display("FAIL off_pulse_pend got %0d/%0b exp 0/0", p3, ia.pend[3]); end
    ia.cnt_sel = 2'd3;
    tick(1);
    checks++; if (ia.cnt_val !== 8'd0) begin errors++; $display("FAIL off_cnt got %0d exp 0", ia.cnt_val); end
    // level[3] is high now; enabling rise must not produce a stale edge
    ia.mode[7:6] = 2'b01;
    p3 = 0;
    for (int t = 0; t < 5; t++) begin
      tick(1);
      if (ia.pulse[3] === 1'b1) p3++;
    end
    checks++; if (p3 != 0 || ia.cnt_val !== 8'd0) begin errors++; $display("FAIL stale_edge got %0d/%0d exp 0/0", p3, ia.cnt_val); end
  endtask

  task automatic test_filter;
    int seen = 0;
    ib.cnt_sel = 2'd0;
    ib.level[0] = 1'b1;
    tick(3);
    ib.level[0] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick(1);
      if (ib.pulse[0] === 1'b1) seen++;
    end
    checks++; if (seen != 0 || ib.cnt_val !== 2'd0) begin errors++; $display("FAIL glitch got %0d/%0d exp 0/0", seen, ib.cnt_val); end
    ib.level[0] = 1'b1;
    tick(6);
    checks++; if (ib.pulse[0] !== 1'b0) begin errors++; $display("FAIL filt_early got %0b exp 0", ib.pulse[0]); end
    ib.level[0] = 1'b0;
    tick(1);
    checks++; if (ib.pulse[0] !== 1'b1) begin errors++; $display("FAIL filt_pulse got %0b exp 1", ib.pulse[0]); end
    tick(1);
    checks++; if (ib.pulse[0] !== 1'b0 || ib.cnt_val !== 2'd1) begin errors++; $display("FAIL filt_after got %0b/%0d exp 0/1", ib.pulse[0], ib.cnt_val); end
    tick(8);
  endtask

  task automatic test_saturate;
    ib.cnt_sel = 2'd1;
    for (int e = 0; e < 5; e++) begin
      ib.level[1] = 1'b1;
      tick(8);
      ib.level[1] = 1'b0;
      tick(8);
    end
    checks++; if (ib.cnt_val !== 2'd3) begin errors++; $display("FAIL saturate got %0d exp 3", ib.cnt_val); end
    ib.pend_clr = 3'b010;
    tick(1);
    ib.pend_clr = 3'b000;
    checks++; if (ib.pend[1] !== 1'b0) begin errors++; $display("FAIL pend_clr_b got %0b exp 0", ib.pend[1]); end
    ib.level[1] = 1'b1;
    tick(6);
    ib.cnt_clr  = 1'b1;
    ib.pend_clr = 3'b010;
    tick(1);
    ib.cnt_clr  = 1'b0;
    ib.pend_clr = 3'b000;
    checks++; if (ib.pulse[1] !== 1'b1) begin errors++; $display("FAIL clr_evt_pulse got %0b exp 1", ib.pulse[1]); end
    checks++; if (ib.cnt_val !== 2'd1) begin errors++; $display("FAIL clr_evt_cnt got %0d exp 1", ib.cnt_val); end
    checks++; if (ib.pend[1] !== 1'b1) begin errors++; $display("FAIL set_wins got %0b exp 1", ib.pend[1]); end
    ib.level[1] = 1'b0;
    tick(8);
  endtask

  task automatic test_out_of_range;
    ib.cnt_sel = 2'd3;
    tick(1);
    checks++; if (ib.cnt_val !== 2'd0) begin errors++; $display("FAIL oor_read got %0d exp 0", ib.cnt_val); end
    ib.cnt_clr = 1'b1;
    tick(1);
    ib.cnt_clr = 1'b0;
    ib.cnt_sel = 2'd0;
    tick(1);
    checks++; if (ib.cnt_val !== 2'd1) begin errors++; $display("FAIL oor_clr_ch0 got %0d exp 1", ib.cnt_val); end
    ib.cnt_sel = 2'd1;
    tick(1);
    checks++; if (ib.cnt_val !== 2'd1) begin errors++; $display("FAIL oor_clr_ch1 got %0d exp 1", ib.cnt_val); end
  endtask

  task automatic test_reset_level;
    ia.cnt_sel = 2'd0;
    ia.level[0] = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    checks++; if (ia.pulse[0] !== 1'b0) begin errors++; $display("FAIL rl_early got %0b exp 0", ia.pulse[0]); end
    tick(1);
    checks++; if (ia.pulse[0] !== 1'b1 || ia.cnt_val !== 8'd1) begin errors++; $display("FAIL rl_pulse got %0b/%0d exp 1/1", ia.pulse[0], ia.cnt_val); end
    tick(1);
    checks++; if (ia.pulse[0] !== 1'b0) begin errors++; $display("FAIL rl_single got %0b exp 0", ia.pulse[0]); end
  endtask

  task automatic test_reset_mid;
    ib.cnt_sel = 2'd2;
    ib.level[2] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    checks++; if (ia.pend !== 4'h0 || ia.any_pend !== 1'b0 || ia.cnt_val !== 8'd0) begin errors++; $display("FAIL mid_rst_a got %0h/%0b/%0d exp 0/0/0", ia.pend, ia.any_pend, ia.cnt_val); end
    checks++; if (ib.pend !== 3'h0 || ib.pulse !== 3'h0) begin errors++; $display("FAIL mid_rst_b got %0h/%0h exp 0/0", ib.pend, ib.pulse); end
    rst = 1'b0;
    tick(6);
    checks++; if (ib.pulse[2] !== 1'b0) begin errors++; $display("FAIL mid_filt_early got %0b exp 0", ib.pulse[2]); end
    tick(1);
    checks++; if (ib.pulse[2] !== 1'b1 || ib.cnt_val !== 2'd1) begin errors++; $display("FAIL mid_filt_pulse got %0b/%0d exp 1/1", ib.pulse[2], ib.cnt_val); end
  endtask

  initial begin
    ia.level = '0; ia.mode = 8'b00_11_10_01; ia.pend_clr = '0; ia.cnt_sel = '0; ia.cnt_clr = 1'b0;
    ib.level = '0; ib.mode = 6'b01_01_01;    ib.pend_clr = '0; ib.cnt_sel = '0; ib.cnt_clr = 1'b0;
    test_reset;
    test_rise;
    test_fall;
    test_both_and_off;
    test_filter;
    test_saturate;
    test_out_of_range;
    test_reset_level;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/px_level2pulse_mc.md
# px_level2pulse_mc

Multi-channel, parametrised level-to-pulse converter for clock-domain crossing of slow level/toggle signals into the `clk` domain. Each channel has:
- a configurable synchroniser chain;
- an optional stability (glitch) filter;
- per-channel edge-mode selection (rise / fall / both / off);
- a registered single-cycle pulse output, a sticky pending flag and a saturating event counter.

It replaces single-channel rising-edge converters wherever several asynchronous status lines enter one domain, such as interrupt sources and external handshake lines.

## Interface
Parameters:
- `CH`, 4, number of channels (1..32).
- `SYNC_STAGES`, 2, synchroniser flops per channel (minimum 2).
- `FILTER`, 0, stability filter length in cycles; 0 bypasses the filter.
- `CNT_W`, 8, event counter width per channel (minimum 1).

Ports (channel i occupies bit i, or bits [2i+1:2i] of `mode`):
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `level`  in  CH  asynchronous level inputs.
- `mode`  in  2*CH  per-channel edge mode: 00 off, 01 rise, 10 fall, 11 both; synchronous to `clk`.
- `pulse`  out  CH  registered one-cycle event pulse.
- `pend`  out  CH  sticky pending flag, set by an event.
- `pend_clr`  in  CH  per-channel pending clear.
- `any_pend`  out  1  OR of `pend`.
- `cnt_sel`  in  max(1,$clog2(CH))  counter read/clear channel select.
- `cnt_clr`  in  1  clear the counter of the `cnt_sel` channel.
- `cnt_val`  out  CNT_W  counter value of the `cnt_sel` channel (combinational mux).

## Operation
Per-channel pipeline: `level` → sync chain → filter → `filt`; `prev` holds the previous cycle's `filt`.

Stability filter (`FILTER`=F>0):
- Counter `fc` (width $clog2(F+1)) and filtered level `filt`.
- If sync out == `filt`: `fc` is set to 0.
- Else if `fc` == F-1: `filt` toggles and `fc` is set to 0.
- Else: `fc` increments.
- Pulses shorter than F cycles after synchronisation are discarded.
- With F=0, `filt` = sync chain output.

Edge detection:
- rise = `filt` & ~`prev`; fall = ~`filt` & `prev`.
- event = (rise & mode[0]) | (fall & mode[1]).

Pulse, pending and counter:
- `pulse` register loads `event` every cycle.
- `pend` sets on `event`; otherwise it clears on `pend_clr`. If set and clear coincide, set wins.
- Counter increments on `event` and saturates at 2^CNT_W-1.
- `cnt_clr` zeroes only the selected channel's counter.
- Counter clear and event on the same channel in the same cycle → counter = 1, so no event is lost.
- An out-of-range `cnt_sel` reads 0, and `cnt_clr` has no effect on it.

Mode handling:
- Mode 00 suppresses pulse, pend set and count. The sync chain, filter and `prev` keep tracking.
- Enabling a channel later therefore never produces a stale edge.
- A mode change applies to the very next cycle's edge evaluation.

Reset (`rst`=1 at a clk edge) zeroes all sync flops, `fc`, `filt`, `prev`, `pulse`, `pend` and counters.
- Outputs read 0 from that edge on.
- A `level` held high through reset yields one rising event after release, with normal latency.
- Reset mid-filter discards the partial count.

## Timing
Edge 1 is the first clk edge sampling a new `level` value.
- Sync out changes at edge `SYNC_STAGES`.
- F=0: `pulse`/`pend`/counter update at edge `SYNC_STAGES`+1; `pulse` falls at edge `SYNC_STAGES`+2.
- F>0: all three update at edge `SYNC_STAGES`+F+1.
- Each accepted transition gives exactly one `pulse` cycle. Back-to-back transitions in mode 11 can hold `pulse` high on consecutive cycles, and each cycle counts.
- The input must hold each value for at least `SYNC_STAGES`+F cycles of `clk` for guaranteed capture. Shorter activity may be lost; it is never duplicated.
- `any_pend` is combinational from `pend`.
- `cnt_val` reflects the counter the same cycle `cnt_sel` changes.

## Test plan
- Channel 0, mode 01, F=0, SYNC_STAGES=2: `level[0]` 0→1 → `pulse[0]` high only during the cycle after edge 3; `pend[0]`=1; `cnt_val` (sel 0)=1. The 1→0 transition gives no pulse.
- Mode 11 on channel 2, level toggling every 10 cycles for 5 transitions → 5 pulses, counter=5. Mode 00 on channel 3 with the same stimulus → no pulse, pend 0, count 0.
- F=4: 3-cycle high glitch → no pulse. 6-cycle high → one pulse at edge `SYNC_STAGES`+5 after onset.
- CNT_W=2: 5 rising events → counter saturates at 3. `cnt_clr` together with an event on the selected channel → counter=1. `pend_clr` together with an event → `pend` stays 1.
- `level` high through reset, `rst` deasserted → one pulse at edge 3 after release. `rst` asserted mid-count → all outputs 0 at the next edge.
- `cnt_sel` ≥ CH → `cnt_val`=0. `cnt_clr` on it leaves all counters unchanged.
